fifo_width_converter: RTL and testbench

Registered width-converting stream FIFO. It packs narrow input words into one wide output word, or splits one wide input word into narrow output words. It sits between the ORAM back-end data path (BEDWidth) and the DRAM-side data path (DDRDWidth), in both the read and write directions. A `Reverse` option selects whether the first narrow word occupies the most- or least-significant slice of the wide word.

---
 rtl/fifo_width_converter_pkg.sv | 35 +++
 rtl/fifo_width_converter.sv | 118 +++++++++++
 tb/tb_fifo_width_converter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_width_converter_pkg.sv
// Shared helpers for fifo_width_converter: conversion mode and width-ratio arithmetic.
package fifo_width_converter_pkg;

    typedef enum logic [1:0] {
        MODE_EQUAL = 2'd0,
        MODE_UP    = 2'd1,
        MODE_DOWN  = 2'd2
    } conv_mode_e;

    function automatic int narrow_width(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int wide_width(input int a, input int b);
        return (a < b) ? b : a;
    endfunction

    function automatic bit widths_compatible(input int a, input int b);
        return (narrow_width(a, b) > 0) && ((wide_width(a, b) % narrow_width(a, b)) == 0);
    endfunction

    function automatic int width_ratio(input int a, input int b);
        return wide_width(a, b) / narrow_width(a, b);
    endfunction

    function automatic conv_mode_e conv_mode(input int in_w, input int out_w);
        if (in_w == out_w)
            return MODE_EQUAL;
        else if (in_w < out_w)
            return MODE_UP;
        else
            return MODE_DOWN;
    endfunction

endpackage

// File: rtl/fifo_width_converter.sv
// Registered stream width converter: packs R narrow words into one wide word,
// splits one wide word into R narrow words, or acts as a register slice when R = 1.
module fifo_width_converter
    import fifo_width_converter_pkg::*;
#(
    parameter int IWidth  = 64,
    parameter int OWidth  = 512,
    parameter int Reverse = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [IWidth-1:0] InData,
    input  logic              InValid,
    output logic              InAccept,
    output logic [OWidth-1:0] OutData,
    output logic              OutValid,
    input  logic              OutReady
);

    localparam int         W      = narrow_width(IWidth, OWidth);
    localparam int         R      = width_ratio(IWidth, OWidth);
    localparam conv_mode_e Mode   = conv_mode(IWidth, OWidth);
    localparam int         CountW = (R < 2) ? 1 : $clog2(R + 1);

    // Narrow slice that holds the i-th word in arrival order.
    function automatic int slice_index(input int i);
        return (Reverse != 0) ? (R - 1 - i) : i;
    endfunction

    logic in_fire;
    logic out_fire;

    assign in_fire  = InValid && InAccept;
    assign out_fire = OutValid && OutReady;

    generate
        if (!widths_compatible(IWidth, OWidth)) begin : g_bad_widths
            $error("fifo_width_converter: wider port must be an integer multiple of the narrower port");
        end else if (Mode == MODE_UP) begin : g_up
            logic [CountW-1:0] count_p0;
            logic [OWidth-1:0] data_p0;

            // A drain and an accept in the same cycle restart the word at count 1.
            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset)
                    count_p0 <= '0;
                else if (out_fire)
                    count_p0 <= in_fire ? CountW'(1) : '0;
                else if (in_fire)
                    count_p0 <= count_p0 + CountW'(1);
            end

            // Shift direction decides whether the first word ends up at the top or the bottom.
            always_ff @(posedge Clock) begin
                if (in_fire) begin
                    if (Reverse != 0)
                        data_p0 <= {data_p0[OWidth-IWidth-1:0], InData};
                    else
                        data_p0 <= {InData, data_p0[OWidth-1:IWidth]};
                end
            end

            assign InAccept = (count_p0 < CountW'(R)) || OutReady;
            assign OutValid = (count_p0 == CountW'(R));
            assign OutData  = data_p0;
        end else if (Mode == MODE_DOWN) begin : g_down
            logic [CountW-1:0] count_p0;
            logic [IWidth-1:0] hold_p0;

            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset)
                    count_p0 <= '0;
                else if (in_fire)
                    count_p0 <= CountW'(R);
                else if (out_fire)
                    count_p0 <= count_p0 - CountW'(1);
            end

            // The current chunk always sits in the slice of the first word; shifting exposes the next.
            always_ff @(posedge Clock) begin
                if (in_fire)
                    hold_p0 <= InData;
                else if (out_fire) begin
                    if (Reverse != 0)
                        hold_p0 <= hold_p0 << W;
                    else
                        hold_p0 <= hold_p0 >> W;
                end
            end

            assign InAccept = (count_p0 == '0) || ((count_p0 == CountW'(1)) && OutReady);
            assign OutValid = (count_p0 != '0);
            assign OutData  = hold_p0[slice_index(0)*W +: W];
        end else begin : g_equal
            logic              vld_p0;
            logic [OWidth-1:0] data_p0;

            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset)
                    vld_p0 <= 1'b0;
                else if (in_fire)
                    vld_p0 <= 1'b1;
                else if (out_fire)
                    vld_p0 <= 1'b0;
            end

            always_ff @(posedge Clock) begin
                if (in_fire)
                    data_p0 <= InData;
            end

            assign InAccept = !vld_p0 || OutReady;
            assign OutValid = vld_p0;
            assign OutData  = data_p0;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_width_converter.sv
// Directed and random-stress bench for fifo_width_converter in up, down and equal-width modes.
module tb_fifo_width_converter;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] UP_BASE = 64'hF000_0000_0000_0000;
    localparam logic [63:0] BP_BASE = 64'hB000_0000_0000_0000;
    localparam logic [63:0] RS_BASE = 64'hC000_0000_0000_0000;
    localparam logic [63:0] ST_BASE = 64'hDEAD_0000_0000_0000;
    localparam int          NWORDS  = 1000;

    logic [63:0]  up1_in;  logic up1_iv, up1_ia; logic [511:0] up1_out; logic up1_ov, up1_or;
    logic [63:0]  up0_in;  logic up0_iv, up0_ia; logic [511:0] up0_out; logic up0_ov, up0_or;
    logic [511:0] dn_in;   logic dn_iv, dn_ia;   logic [63:0]  dn_out;  logic dn_ov, dn_or;
    logic [15:0]  eq_in;   logic eq_iv, eq_ia;   logic [15:0]  eq_out;  logic eq_ov, eq_or;
    logic [63:0]  cu_in;   logic cu_iv, cu_ia;
    logic [511:0] mid_data; logic mid_valid, mid_ready;
    logic [63:0]  cd_out;  logic cd_ov, cd_or;

    logic [63:0] src [NWORDS];

    fifo_width_converter #(.IWidth(64), .OWidth(512), .Reverse(1)) u_up1 (
        .Clock(Clock), .Reset(Reset), .InData(up1_in), .InValid(up1_iv), .InAccept(up1_ia),
        .OutData(up1_out), .OutValid(up1_ov), .OutReady(up1_or));

    fifo_width_converter #(.IWidth(64), .OWidth(512), .Reverse(0)) u_up0 (
        .Clock(Clock), .Reset(Reset), .InData(up0_in), .InValid(up0_iv), .InAccept(up0_ia),
        .OutData(up0_out), .OutValid(up0_ov), .OutReady(up0_or));

    fifo_width_converter #(.IWidth(512), .OWidth(64), .Reverse(1)) u_dn (
        .Clock(Clock), .Reset(Reset), .InData(dn_in), .InValid(dn_iv), .InAccept(dn_ia),
        .OutData(dn_out), .OutValid(dn_ov), .OutReady(dn_or));

    fifo_width_converter #(.IWidth(16), .OWidth(16), .Reverse(0)) u_eq (
        .Clock(Clock), .Reset(Reset), .InData(eq_in), .InValid(eq_iv), .InAccept(eq_ia),
        .OutData(eq_out), .OutValid(eq_ov), .OutReady(eq_or));

    fifo_width_converter #(.IWidth(64), .OWidth(512), .Reverse(0)) u_cu (
        .Clock(Clock), .Reset(Reset), .InData(cu_in), .InValid(cu_iv), .InAccept(cu_ia),
        .OutData(mid_data), .OutValid(mid_valid), .OutReady(mid_ready));

    fifo_width_converter #(.IWidth(512), .OWidth(64), .Reverse(0)) u_cd (
        .Clock(Clock), .Reset(Reset), .InData(mid_data), .InValid(mid_valid), .InAccept(mid_ready),
        .OutData(cd_out), .OutValid(cd_ov), .OutReady(cd_or));

    function automatic logic [511:0] pack_seq(input logic [63:0] base, input bit rev);
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (rev) r[511-64*k -: 64] = base + 64'(k);
            else     r[64*k +: 64]     = base + 64'(k);
        end
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_all();
        up1_iv = 0; up1_in = '0; up1_or = 0;
        up0_iv = 0; up0_in = '0; up0_or = 0;
        dn_iv = 0;  dn_in = '0;  dn_or = 0;
        eq_iv = 0;  eq_in = '0;  eq_or = 0;
        cu_iv = 0;  cu_in = '0;  cd_or = 0;
    endtask

    task automatic test_reset();
        idle_all();
        #2;
        checks++; if (up1_ov !== 1'b0) begin errors++; $display("FAIL reset_up_valid: got %b expected 0", up1_ov); end
        checks++; if (up1_ia !== 1'b1) begin errors++; $display("FAIL reset_up_accept: got %b expected 1", up1_ia); end
        checks++; if (dn_ov !== 1'b0)  begin errors++; $display("FAIL reset_dn_valid: got %b expected 0", dn_ov); end
        checks++; if (dn_ia !== 1'b1)  begin errors++; $display("FAIL reset_dn_accept: got %b expected 1", dn_ia); end
        checks++; if (eq_ov !== 1'b0)  begin errors++; $display("FAIL reset_eq_valid: got %b expected 0", eq_ov); end
        checks++; if (eq_ia !== 1'b1)  begin errors++; $display("FAIL reset_eq_accept: got %b expected 1", eq_ia); end
        repeat (2) next_cycle();
        Reset = 1'b1;
        next_cycle();
        checks++; if (cd_ov !== 1'b0)  begin errors++; $display("FAIL post_reset_chain_valid: got %b expected 0", cd_ov); end
        checks++; if (up0_ov !== 1'b0) begin errors++; $display("FAIL post_reset_up0_valid: got %b expected 0", up0_ov); end
    endtask

    task automatic test_up_order();
        logic [511:0] exp1, exp0;
        exp1 = pack_seq(UP_BASE, 1'b1);
        exp0 = pack_seq(UP_BASE, 1'b0);
        up1_or = 0; up0_or = 0;
        for (int k = 0; k < 8; k++) begin
            up1_iv = 1; up1_in = UP_BASE + 64'(k);
            up0_iv = 1; up0_in = UP_BASE + 64'(k);
            #1;
            checks++; if (up1_ia !== 1'b1) begin errors++; $display("FAIL up_accept_%0d: got %b expected 1", k, up1_ia); end
            checks++; if (up1_ov !== 1'b0) begin errors++; $display("FAIL up_early_valid_%0d: got %b expected 0", k, up1_ov); end
            next_cycle();
        end
        up1_iv = 0; up0_iv = 0;
        #1;
        checks++; if (up1_ov !== 1'b1) begin errors++; $display("FAIL up_rev1_latency: valid %b expected 1", up1_ov); end
        checks++; if (up1_out !== exp1) begin errors++; $display("FAIL up_rev1_data: got %h expected %h", up1_out, exp1); end
        checks++; if (up1_ia !== 1'b0) begin errors++; $display("FAIL up_full_accept: got %b expected 0", up1_ia); end
        checks++; if (up0_ov !== 1'b1) begin errors++; $display("FAIL up_rev0_latency: valid %b expected 1", up0_ov); end
        checks++; if (up0_out !== exp0) begin errors++; $display("FAIL up_rev0_data: got %h expected %h", up0_out, exp0); end
        up1_or = 1; up0_or = 1;
        next_cycle();
        checks++; if (up1_ov !== 1'b0) begin errors++; $display("FAIL up_rev1_drain: valid %b expected 0", up1_ov); end
        checks++; if (up0_ov !== 1'b0) begin errors++; $display("FAIL up_rev0_drain: valid %b expected 0", up0_ov); end
        up1_or = 0; up0_or = 0;
    endtask

    task automatic test_down_order();
        logic [511:0] w1, w2;
        logic [63:0]  exp;
        w1 = pack_seq(64'h1000, 1'b1);
        w2 = pack_seq(64'h1008, 1'b1);
        dn_or = 1;
        for (int c = 0; c < 18; c++) begin
            dn_iv = (c == 0) || (c == 8);
            dn_in = (c == 0) ? w1 : w2;
            #1;
            if (c == 0 || c == 8) begin
                checks++; if (dn_ia !== 1'b1) begin errors++; $display("FAIL dn_accept_c%0d: got %b expected 1", c, dn_ia); end
            end
            if (c == 1) begin
                checks++; if (dn_ia !== 1'b0) begin errors++; $display("FAIL dn_busy_accept: got %b expected 0", dn_ia); end
            end
            if (c == 0 || c == 17) begin
                checks++; if (dn_ov !== 1'b0) begin errors++; $display("FAIL dn_idle_valid_c%0d: got %b expected 0", c, dn_ov); end
            end else begin
                exp = 64'h1000 + 64'(c - 1);
                checks++; if (dn_ov !== 1'b1) begin errors++; $display("FAIL dn_valid_c%0d: got %b expected 1", c, dn_ov); end
                checks++; if (dn_out !== exp) begin errors++; $display("FAIL dn_chunk_c%0d: got %h expected %h", c, dn_out, exp); end
            end
            next_cycle();
        end
        dn_iv = 0; dn_or = 0;
    endtask

    task automatic test_backpressure();
        logic [511:0] exp_a, exp_b;
        exp_a = pack_seq(BP_BASE, 1'b0);
        exp_b = pack_seq(BP_BASE + 64'd8, 1'b0);
        up0_or = 0;
        for (int k = 0; k < 8; k++) begin
            up0_iv = 1; up0_in = BP_BASE + 64'(k);
            next_cycle();
        end
        for (int n = 0; n < 20; n++) begin
            up0_iv = 1; up0_in = BP_BASE + 64'd8;
            #1;
            checks++; if (up0_ia !== 1'b0) begin errors++; $display("FAIL bp_accept_%0d: got %b expected 0", n, up0_ia); end
            checks++; if (up0_ov !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d: got %b expected 1", n, up0_ov); end
            checks++; if (up0_out !== exp_a) begin errors++; $display("FAIL bp_hold_%0d: got %h expected %h", n, up0_out, exp_a); end
            next_cycle();
        end
        up0_or = 1;
        #1;
        checks++; if (up0_ia !== 1'b1) begin errors++; $display("FAIL bp_release_accept: got %b expected 1", up0_ia); end
        next_cycle();
        for (int k = 9; k < 16; k++) begin
            up0_in = BP_BASE + 64'(k);
            #1;
            checks++; if (up0_ov !== 1'b0) begin errors++; $display("FAIL bp_refill_valid_%0d: got %b expected 0", k, up0_ov); end
            next_cycle();
        end
        up0_iv = 0;
        #1;
        checks++; if (up0_ov !== 1'b1) begin errors++; $display("FAIL bp_second_valid: got %b expected 1", up0_ov); end
        checks++; if (up0_out !== exp_b) begin errors++; $display("FAIL bp_second_data: got %h expected %h", up0_out, exp_b); end
        next_cycle();
        up0_or = 0;
    endtask

    task automatic test_reset_midword();
        logic [511:0] exp;
        exp = pack_seq(RS_BASE, 1'b1);
        up1_or = 0;
        for (int k = 0; k < 3; k++) begin
            up1_iv = 1; up1_in = ST_BASE + 64'(k);
            next_cycle();
        end
        up1_iv = 0;
        Reset = 1'b0;
        #1;
        checks++; if (up1_ov !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", up1_ov); end
        checks++; if (up1_ia !== 1'b1) begin errors++; $display("FAIL rst_mid_accept: got %b expected 1", up1_ia); end
        #1;
        Reset = 1'b1;
        next_cycle();
        for (int k = 0; k < 8; k++) begin
            up1_iv = 1; up1_in = RS_BASE + 64'(k);
            #1;
            checks++; if (up1_ov !== 1'b0) begin errors++; $display("FAIL rst_stale_valid_%0d: got %b expected 0", k, up1_ov); end
            next_cycle();
        end
        up1_iv = 0;
        #1;
        checks++; if (up1_ov !== 1'b1) begin errors++; $display("FAIL rst_clean_valid: got %b expected 1", up1_ov); end
        checks++; if (up1_out !== exp) begin errors++; $display("FAIL rst_clean_data: got %h expected %h", up1_out, exp); end
        up1_or = 1;
        next_cycle();
        up1_or = 0;
    endtask

    task automatic test_equal_width();
        eq_iv = 1; eq_in = 16'hABCD; eq_or = 0;
        next_cycle();
        eq_in = 16'h1234;
        #1;
        checks++; if (eq_ov !== 1'b1)     begin errors++; $display("FAIL eq_valid: got %b expected 1", eq_ov); end
        checks++; if (eq_out !== 16'hABCD) begin errors++; $display("FAIL eq_data: got %h expected abcd", eq_out); end
        checks++; if (eq_ia !== 1'b0)     begin errors++; $display("FAIL eq_full_accept: got %b expected 0", eq_ia); end
        next_cycle();
        eq_or = 1;
        #1;
        checks++; if (eq_ia !== 1'b1)     begin errors++; $display("FAIL eq_pass_accept: got %b expected 1", eq_ia); end
        checks++; if (eq_out !== 16'hABCD) begin errors++; $display("FAIL eq_hold: got %h expected abcd", eq_out); end
        next_cycle();
        eq_iv = 0;
        #1;
        checks++; if (eq_out !== 16'h1234) begin errors++; $display("FAIL eq_second: got %h expected 1234", eq_out); end
        next_cycle();
        checks++; if (eq_ov !== 1'b0)     begin errors++; $display("FAIL eq_drain: got %b expected 0", eq_ov); end
        eq_or = 0;
    endtask

    task automatic test_random_stress();
        int sent;
        int recv;
        int cycles;
        sent = 0; recv = 0; cycles = 0;
        for (int i = 0; i < NWORDS; i++) src[i] = {$urandom, $urandom};
        while (recv < NWORDS && cycles < 20000) begin
            cu_iv = (sent < NWORDS) && ($urandom_range(1) == 1);
            cu_in = (sent < NWORDS) ? src[sent] : 64'd0;
            cd_or = ($urandom_range(1) == 1);
            #1;
            if (cd_ov && cd_or) begin
                checks++;
                if (cd_out !== src[recv]) begin
                    errors++;
                    $display("FAIL stress_word_%0d: got %h expected %h", recv, cd_out, src[recv]);
                end
                recv++;
            end
            if (cu_iv && cu_ia) sent++;
            next_cycle();
            cycles++;
        end
        cu_iv = 0; cd_or = 0;
        checks++; if (recv != NWORDS) begin errors++; $display("FAIL stress_count: got %0d words expected %0d", recv, NWORDS); end
        #1;
        checks++; if (cd_ov !== 1'b0) begin errors++; $display("FAIL stress_extra: valid %b expected 0", cd_ov); end
    endtask

    initial begin
        Reset = 1'b0;
        test_reset();
        test_up_order();
        test_down_order();
        test_backpressure();
        test_reset_midword();
        test_equal_width();
        test_random_stress();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
